l2_mem_bridge: RTL

- Sits directly downstream of the unified L2 data cache's external memory port.
- Accepts block-granular read and write requests and serialises each L2 block into sub-block beats on a single-ported backing memory.
- The backing memory is a synchronous RAM with 1-cycle read latency.
- A programmable access latency models off-chip DRAM delay; the block is the default memory model for simulation and FPGA bring-up.

---
 rtl/l2_mem_bridge_pkg.sv | 25 ++
 rtl/l2_mem_beat_ctr.sv | 69 ++++++
 rtl/l2_mem_bridge.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/l2_mem_bridge_pkg.sv
// Shared L2 geometry defaults, bridge FSM encoding and address helpers
// for the L2 external-memory bridge.
package l2_mem_bridge_pkg;

   localparam int unsigned L2_ADDR_BITS  = 32;
   localparam int unsigned L2_BLOCK_BITS = 512;
   localparam int unsigned L2_SB_LOG2    = 2;
   localparam int unsigned L2_MEM_AW     = 20;
   localparam int unsigned L2_LATENCY    = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RD,
      ST_RD_LAST,
      ST_WR,
      ST_DONE
   } state_e;

   // Number of byte-offset bits inside one L2 block.
   function automatic int unsigned off_bits(input int unsigned block_bits);
      return $clog2(block_bits / 8);
   endfunction

endpackage

// File: rtl/l2_mem_beat_ctr.sv
// Beat counter, latency down-counter and backing-memory word-address
// generator for one L2 block transfer.
module l2_mem_beat_ctr
   import l2_mem_bridge_pkg::*;
#(
   parameter int unsigned ADDR_BITS  = L2_ADDR_BITS,
   parameter int unsigned BLOCK_BITS = L2_BLOCK_BITS,
   parameter int unsigned SB_LOG2    = L2_SB_LOG2,
   parameter int unsigned MEM_AW     = L2_MEM_AW,
   parameter int unsigned LATENCY    = L2_LATENCY
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic                 lat_dec,
   input  logic                 cnt_inc,
   output logic [SB_LOG2-1:0]   cnt,
   output logic [MEM_AW-1:0]    word_addr,
   output logic                 last,
   output logic                 lat_done
);

   localparam int unsigned OFF  = off_bits(BLOCK_BITS);
   localparam int unsigned WIDE = ADDR_BITS - OFF + SB_LOG2;

   logic [SB_LOG2-1:0] cnt_q, cnt_d;
   logic [7:0]         lat_q, lat_d;
   logic [MEM_AW-1:0]  base_q, base_d;
   logic [WIDE-1:0]    base_wide;
   logic               unused_addr_bits;

   always_comb begin
      // Block index followed by SB_LOG2 zero bits gives the first word of the block.
      base_wide        = {addr[ADDR_BITS-1:OFF], {SB_LOG2{1'b0}}};
      unused_addr_bits = ^addr[OFF-1:0];
      cnt_d            = cnt_q;
      lat_d            = lat_q;
      base_d           = base_q;
      if (load) begin
         cnt_d  = '0;
         lat_d  = 8'(LATENCY);
         base_d = MEM_AW'(base_wide);
      end else begin
         if (lat_dec) lat_d = lat_q - 8'd1;
         if (cnt_inc) cnt_d = cnt_q + SB_LOG2'(1);
      end
   end

   always_comb begin
      cnt       = cnt_q;
      word_addr = base_q + MEM_AW'(cnt_q);
      last      = (cnt_q == '1);
      lat_done  = (lat_q == 8'd1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         lat_q  <= '0;
         base_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         lat_q  <= lat_d;
         base_q <= base_d;
      end
   end

endmodule

// File: rtl/l2_mem_bridge.sv
// L2 external-memory bridge: serialises block reads/writes into sub-block
// beats on a single-ported synchronous RAM after a programmable latency.
module l2_mem_bridge
   import l2_mem_bridge_pkg::*;
#(
   parameter  int unsigned ADDR_BITS  = L2_ADDR_BITS,
   parameter  int unsigned BLOCK_BITS = L2_BLOCK_BITS,
   parameter  int unsigned SB_LOG2    = L2_SB_LOG2,
   parameter  int unsigned MEM_AW     = L2_MEM_AW,
   parameter  int unsigned LATENCY    = L2_LATENCY,
   localparam int unsigned SB_BITS    = BLOCK_BITS >> SB_LOG2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ADDR_BITS-1:0] addrD,
   input  logic                 enD,
   input  logic                 weD,
   input  logic [SB_LOG2-1:0]   doutDstrobe,
   input  logic [SB_BITS-1:0]   doutD,
   output logic [SB_LOG2-1:0]   dinDstrobe,
   output logic [SB_BITS-1:0]   dinD,
   output logic                 readyD,
   output logic                 accR,
   output logic                 accW,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [MEM_AW-1:0]    mem_addr,
   output logic [SB_BITS-1:0]   mem_wdata,
   input  logic [SB_BITS-1:0]   mem_rdata,
   output logic [31:0]          rd_blocks,
   output logic [31:0]          wr_blocks
);

   state_e             state_q, state_d;
   logic               we_q, we_d;
   logic               acc_r_q, acc_r_d;
   logic               acc_w_q, acc_w_d;
   logic               rd_vld_q, rd_vld_d;
   logic [SB_LOG2-1:0] dstb_q, dstb_d;
   logic [SB_BITS-1:0] dind_q, dind_d;
   logic [31:0]        rd_cnt_q, rd_cnt_d;
   logic [31:0]        wr_cnt_q, wr_cnt_d;

   logic               ctr_load, lat_dec, cnt_inc;
   logic [SB_LOG2-1:0] cnt;
   logic [MEM_AW-1:0]  word_addr;
   logic               last, lat_done;
   logic               wr_hit;

   l2_mem_beat_ctr #(
      .ADDR_BITS  (ADDR_BITS),
      .BLOCK_BITS (BLOCK_BITS),
      .SB_LOG2    (SB_LOG2),
      .MEM_AW     (MEM_AW),
      .LATENCY    (LATENCY)
   ) u_ctr (
      .clk       (clk),
      .rst_n     (reset),
      .load      (ctr_load),
      .addr      (addrD),
      .lat_dec   (lat_dec),
      .cnt_inc   (cnt_inc),
      .cnt       (cnt),
      .word_addr (word_addr),
      .last      (last),
      .lat_done  (lat_done)
   );

   always_comb begin
      wr_hit   = (state_q == ST_WR) && (doutDstrobe == cnt);
      state_d  = state_q;
      we_d     = we_q;
      acc_r_d  = 1'b0;
      acc_w_d  = 1'b0;
      ctr_load = 1'b0;
      lat_dec  = 1'b0;
      cnt_inc  = 1'b0;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      rd_vld_d = (state_q == ST_RD);
      dstb_d   = (state_q == ST_RD) ? cnt : dstb_q;
      dind_d   = rd_vld_q ? mem_rdata : dind_q;
      unique case (state_q)
         ST_IDLE: begin
            if (enD) begin
               ctr_load = 1'b1;
               we_d     = weD;
               acc_r_d  = !weD;
               acc_w_d  = weD;
               if (LATENCY == 0) state_d = weD ? ST_WR : ST_RD;
               else              state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            lat_dec = 1'b1;
            if (lat_done) state_d = we_q ? ST_WR : ST_RD;
         end
         ST_RD: begin
            cnt_inc = 1'b1;
            if (last) state_d = ST_RD_LAST;
         end
         ST_RD_LAST: begin
            rd_cnt_d = rd_cnt_q + 32'd1;
            state_d  = ST_IDLE;
         end
         ST_WR: begin
            if (wr_hit) begin
               cnt_inc = 1'b1;
               if (last) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            wr_cnt_d = wr_cnt_q + 32'd1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // RAM data already lags its request by one cycle, so it is forwarded in the
   // arrival cycle and held afterwards; this puts sub-block N-1 under readyD.
   always_comb begin
      mem_en     = (state_q == ST_RD) || wr_hit;
      mem_we     = wr_hit;
      mem_addr   = word_addr;
      mem_wdata  = wr_hit ? doutD : '0;
      readyD     = (state_q == ST_RD_LAST) || (state_q == ST_DONE);
      accR       = acc_r_q;
      accW       = acc_w_q;
      dinD       = rd_vld_q ? mem_rdata : dind_q;
      dinDstrobe = dstb_q;
      rd_blocks  = rd_cnt_q;
      wr_blocks  = wr_cnt_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         acc_r_q  <= 1'b0;
         acc_w_q  <= 1'b0;
         rd_vld_q <= 1'b0;
         dstb_q   <= '0;
         dind_q   <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         acc_r_q  <= acc_r_d;
         acc_w_q  <= acc_w_d;
         rd_vld_q <= rd_vld_d;
         dstb_q   <= dstb_d;
         dind_q   <= dind_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

endmodule
